// File: rtl/sdram_pkg.sv
// ============================================================================
// Module : sdram_pkg
// Brief  : Shared SDR SDRAM command encodings, bus widths, and the init FSM state type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sdram_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned BA_W   = 2;
  localparam int unsigned DQ_W   = 16;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  // Burst write, CAS latency 3, sequential, full page
  localparam logic [ADDR_W-1:0] MODE_REG_DEFAULT = 12'b00_0_00_011_0_111;

  // A10 high selects all banks for PRECHARGE
  localparam logic [ADDR_W-1:0] ADDR_PRE_ALL = 12'h400;

  typedef enum logic [2:0] {
    ST_WAIT = 3'd0,
    ST_PRE  = 3'd1,
    ST_TRP  = 3'd2,
    ST_AREF = 3'd3,
    ST_TRFC = 3'd4,
    ST_MRS  = 3'd5,
    ST_TMRD = 3'd6,
    ST_DONE = 3'd7
  } init_state_e;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_cycle_cnt.sv
// ============================================================================
// Module : sdram_cycle_cnt
// Brief  : Loadable saturating down-counter with a zero flag, used for init delays.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_cycle_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Stops at zero so an idle counter never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/sdram_init_seq.sv
// ============================================================================
// Module : sdram_init_seq
// Brief  : SDR SDRAM power-up sequencer: wait, PRECHARGE-ALL, N x AUTO-REFRESH, LOAD-MODE.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int unsigned       T_WAIT   = 20000,
  parameter int unsigned       T_RP     = 2,
  parameter int unsigned       T_RFC    = 7,
  parameter int unsigned       T_MRD    = 3,
  parameter int unsigned       AREF_NUM = 8,
  parameter logic [ADDR_W-1:0] MODE_REG = MODE_REG_DEFAULT
) (
  input  logic              sclk,
  input  logic              srst,
  output logic              dram_clk,
  output logic              dram_cke,
  output logic              dram_cs_n,
  output logic              dram_ras_n,
  output logic              dram_cas_n,
  output logic              dram_we_n,
  output logic [BA_W-1:0]   dram_ba,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_ldqm,
  output logic              dram_udqm,
  inout  wire  [DQ_W-1:0]   dram_dq,
  output logic              init_done
);

  localparam int unsigned c_CNT_W = cnt_width(T_WAIT, T_RP, T_RFC, T_MRD);
  localparam int unsigned c_REF_W = $clog2(AREF_NUM + 1);

  // Reload values: a timed state lasting N cycles is entered with N-1 loaded,
  // so the post-command gaps below load (T_x - 1) - 1.
  localparam logic [c_CNT_W-1:0] c_LD_WAIT = c_CNT_W'(T_WAIT - 1);
  localparam logic [c_CNT_W-1:0] c_LD_RP   = c_CNT_W'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [c_CNT_W-1:0] c_LD_RFC  = c_CNT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [c_CNT_W-1:0] c_LD_MRD  = c_CNT_W'((T_MRD > 1) ? T_MRD - 2 : 0);
  localparam logic [c_REF_W-1:0] c_REF_MAX = c_REF_W'(AREF_NUM);
  localparam logic [c_REF_W-1:0] c_REF_PEN = c_REF_W'(AREF_NUM - 1);

  init_state_e         state_q;
  init_state_e         state_d;
  logic                armed_q;
  logic                armed_d;
  logic [c_REF_W-1:0]  ref_q;
  logic [c_REF_W-1:0]  ref_d;
  logic [3:0]          cmd_q;
  logic [3:0]          cmd_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_d;
  logic                done_q;
  logic                done_d;

  logic                w_cnt_load;
  logic [c_CNT_W-1:0]  w_cnt_val;
  logic                w_cnt_zero;

  sdram_cycle_cnt #(
    .WIDTH (c_CNT_W)
  ) u_cycle_cnt (
    .clk_i      (sclk),
    .rst_i      (srst),
    .load_i     (w_cnt_load),
    .load_val_i (w_cnt_val),
    .zero_o     (w_cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    ref_d      = ref_q;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;

    case (state_q)
      // The counter comes out of reset at zero, so the first WAIT cycle arms it
      ST_WAIT: begin
        if (!armed_q) begin
          armed_d    = 1'b1;
          w_cnt_load = 1'b1;
          w_cnt_val  = c_LD_WAIT;
        end else if (w_cnt_zero) begin
          state_d = ST_PRE;
        end
      end

      ST_PRE: begin
        if (T_RP > 1) begin
          state_d    = ST_TRP;
          w_cnt_load = 1'b1;
          w_cnt_val  = c_LD_RP;
        end else begin
          state_d = ST_AREF;
        end
      end

      ST_TRP: begin
        if (w_cnt_zero) state_d = ST_AREF;
      end

      ST_AREF: begin
        ref_d = ref_q + 1'b1;
        if (T_RFC > 1) begin
          state_d    = ST_TRFC;
          w_cnt_load = 1'b1;
          w_cnt_val  = c_LD_RFC;
        end else if (ref_q == c_REF_PEN) begin
          state_d = ST_MRS;
        end else begin
          state_d = ST_AREF;
        end
      end

      ST_TRFC: begin
        if (w_cnt_zero) begin
          state_d = (ref_q == c_REF_MAX) ? ST_MRS : ST_AREF;
        end
      end

      ST_MRS: begin
        if (T_MRD > 1) begin
          state_d    = ST_TMRD;
          w_cnt_load = 1'b1;
          w_cnt_val  = c_LD_MRD;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_TMRD: begin
        if (w_cnt_zero) state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // Pin values are decoded from the next state and then registered
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    done_d = (state_d == ST_DONE);
    case (state_d)
      ST_PRE: begin
        cmd_d  = CMD_PRE;
        addr_d = ADDR_PRE_ALL;
      end
      ST_AREF: begin
        cmd_d = CMD_AREF;
      end
      ST_MRS: begin
        cmd_d  = CMD_MRS;
        addr_d = MODE_REG;
      end
      default: begin
        cmd_d = CMD_NOP;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      state_q <= ST_WAIT;
      armed_q <= 1'b0;
      ref_q   <= '0;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      ref_q   <= ref_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign dram_clk   = ~sclk;
  assign dram_cke   = 1'b1;
  assign dram_ldqm  = 1'b1;
  assign dram_udqm  = 1'b1;
  assign dram_ba    = '0;
  assign dram_cs_n  = cmd_q[3];
  assign dram_ras_n = cmd_q[2];
  assign dram_cas_n = cmd_q[1];
  assign dram_we_n  = cmd_q[0];
  assign dram_addr  = addr_q;
  assign init_done  = done_q;
  assign dram_dq    = {DQ_W{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_sdram_init_seq.sv
// ============================================================================
// Module : tb_sdram_init_seq
// Brief  : Self-checking bench for sdram_init_seq (directed table, random resets, defaults).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sdram_init_seq;

  localparam int P_WAIT = 10;
  localparam int P_RP   = 2;
  localparam int P_RFC  = 7;
  localparam int P_NREF = 2;
  localparam int P_MRD  = 3;

  localparam logic [3:0]  NOP  = 4'b0111;
  localparam logic [3:0]  PRE  = 4'b0010;
  localparam logic [3:0]  AREF = 4'b0001;
  localparam logic [3:0]  MRS  = 4'b0000;
  localparam logic [11:0] MODE = 12'h037;

  logic sclk;
  logic srst;
  logic srst_def;

  logic        dclk, cke, cs_n, ras_n, cas_n, we_n, ldqm, udqm, done;
  logic [1:0]  ba;
  logic [11:0] addr;
  wire  [15:0] dq;

  logic        d_dclk, d_cke, d_cs_n, d_ras_n, d_cas_n, d_we_n, d_ldqm, d_udqm, d_done;
  logic [1:0]  d_ba;
  logic [11:0] d_addr;
  wire  [15:0] d_dq;

  sdram_init_seq #(
    .T_WAIT(P_WAIT), .T_RP(P_RP), .T_RFC(P_RFC), .T_MRD(P_MRD), .AREF_NUM(P_NREF)
  ) dut (
    .sclk(sclk), .srst(srst), .dram_clk(dclk), .dram_cke(cke), .dram_cs_n(cs_n),
    .dram_ras_n(ras_n), .dram_cas_n(cas_n), .dram_we_n(we_n), .dram_ba(ba),
    .dram_addr(addr), .dram_ldqm(ldqm), .dram_udqm(udqm), .dram_dq(dq), .init_done(done)
  );

  sdram_init_seq dut_def (
    .sclk(sclk), .srst(srst_def), .dram_clk(d_dclk), .dram_cke(d_cke), .dram_cs_n(d_cs_n),
    .dram_ras_n(d_ras_n), .dram_cas_n(d_cas_n), .dram_we_n(d_we_n), .dram_ba(d_ba),
    .dram_addr(d_addr), .dram_ldqm(d_ldqm), .dram_udqm(d_udqm), .dram_dq(d_dq),
    .init_done(d_done)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int checks   = 0;
  int failures = 0;
  int n        = -1;   // cycle index since release; -1 while in reset
  int cnt_pre, cnt_aref, cnt_mrs;

  int def_pre      = -1;
  int def_done     = -1;
  bit def_finished = 1'b0;

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic        done;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [3:0] cur_cmd();
    return {cs_n, ras_n, cas_n, we_n};
  endfunction

  // Expected pins at cycle k, from the documented event schedule
  task automatic model(input int k, output logic [3:0] ecmd, output logic [11:0] eaddr,
                       output logic edone);
    int t_refs;
    ecmd  = NOP;
    eaddr = 12'h000;
    edone = 1'b0;
    if (k >= 0) begin
      t_refs = P_WAIT + P_RP;
      if (k == P_WAIT) begin
        ecmd  = PRE;
        eaddr = 12'h400;
      end
      for (int i = 0; i < P_NREF; i++)
        if (k == t_refs + i * P_RFC) ecmd = AREF;
      if (k == t_refs + P_NREF * P_RFC) begin
        ecmd  = MRS;
        eaddr = MODE;
      end
      edone = (k >= t_refs + P_NREF * P_RFC + P_MRD);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at n=%0d: got %h expected %h", nm, n, act, exp);
    end
  endtask

  task automatic step(input logic rst);
    srst = rst;
    @(posedge sclk);
    #1;
    if (rst) n = -1;
    else     n = n + 1;
  endtask

  task automatic cmp_model();
    logic [3:0]  ecmd;
    logic [11:0] eaddr;
    logic        edone;
    model(n, ecmd, eaddr, edone);
    check("cmd",  {28'd0, cur_cmd()}, {28'd0, ecmd});
    check("addr", {20'd0, addr}, {20'd0, eaddr});
    check("done", {31'd0, done}, {31'd0, edone});
    check("static", {26'd0, dclk, cke, ldqm, udqm, ba}, {26'd0, 6'b011100});
    if (cur_cmd() == PRE)  cnt_pre++;
    if (cur_cmd() == AREF) cnt_aref++;
    if (cur_cmd() == MRS)  cnt_mrs++;
  endtask

  // Default-parameter instance runs alongside the main flow
  initial begin
    int dn;
    srst_def = 1'b1;
    repeat (3) @(posedge sclk);
    #1 srst_def = 1'b0;
    dn = -1;
    while (def_done < 0 && dn < 30000) begin
      @(posedge sclk);
      #1;
      dn++;
      if ({d_cs_n, d_ras_n, d_cas_n, d_we_n} == PRE && def_pre < 0) def_pre = dn;
      if (d_done && def_done < 0) def_done = dn;
    end
    def_finished = 1'b1;
  end

  initial begin
    int nonnop;
    logic rst_r;
    int burst;

    vecs[0]  = '{0,  NOP,  12'h000, 1'b0};
    vecs[1]  = '{9,  NOP,  12'h000, 1'b0};
    vecs[2]  = '{10, PRE,  12'h400, 1'b0};
    vecs[3]  = '{11, NOP,  12'h000, 1'b0};
    vecs[4]  = '{12, AREF, 12'h000, 1'b0};
    vecs[5]  = '{13, NOP,  12'h000, 1'b0};
    vecs[6]  = '{18, NOP,  12'h000, 1'b0};
    vecs[7]  = '{19, AREF, 12'h000, 1'b0};
    vecs[8]  = '{25, NOP,  12'h000, 1'b0};
    vecs[9]  = '{26, MRS,  MODE,    1'b0};
    vecs[10] = '{27, NOP,  12'h000, 1'b0};
    vecs[11] = '{28, NOP,  12'h000, 1'b0};
    vecs[12] = '{29, NOP,  12'h000, 1'b1};
    vecs[13] = '{40, NOP,  12'h000, 1'b1};

    srst = 1'b1;
    cnt_pre = 0; cnt_aref = 0; cnt_mrs = 0;

    // Reset held: pins pinned at reset values
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      check("rst_cmd",  {28'd0, cur_cmd()}, {28'd0, NOP});
      check("rst_addr", {20'd0, addr}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_static", {26'd0, dclk, cke, ldqm, udqm, ba}, {26'd0, 6'b011100});
    end

    // Directed table after release
    for (int v = 0; v < 14; v++) begin
      while (n < vecs[v].cyc) step(1'b0);
      check("tbl_cmd",  {28'd0, cur_cmd()}, {28'd0, vecs[v].cmd});
      check("tbl_addr", {20'd0, addr}, {20'd0, vecs[v].addr});
      check("tbl_done", {31'd0, done}, {31'd0, vecs[v].done});
    end

    // Quiet after completion
    nonnop = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0);
      if (cur_cmd() != NOP) nonnop++;
      check("post_done", {31'd0, done}, 32'd1);
    end
    check("post_nonnop", nonnop, 32'd0);

    // Fresh sequence, then a one-cycle reset at cycle 15
    step(1'b1);
    while (n < 14) step(1'b0);
    step(1'b1);
    check("midrst_cmd",  {28'd0, cur_cmd()}, {28'd0, NOP});
    check("midrst_done", {31'd0, done}, 32'd0);
    cnt_pre = 0; cnt_aref = 0; cnt_mrs = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      cmp_model();
    end
    check("count_pre",  cnt_pre,  32'd1);
    check("count_aref", cnt_aref, P_NREF);
    check("count_mrs",  cnt_mrs,  32'd1);

    // Random reset pulses against the schedule model
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst > 0) begin
        burst--;
        rst_r = 1'b1;
      end else if ($urandom_range(0, 99) < 2) begin
        burst = $urandom_range(0, 3);
        rst_r = 1'b1;
      end else begin
        rst_r = 1'b0;
      end
      step(rst_r);
      cmp_model();
    end

    // Default parameters
    for (int i = 0; i < 30000 && !def_finished; i++) @(posedge sclk);
    #2;
    check("def_finished", {31'd0, def_finished}, 32'd1);
    check("def_pre_cycle",  def_pre,  32'd20000);
    check("def_done_cycle", def_done, 32'd20061);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
